// File: rtl/rca_cfg_decoder.sv
// Decodes and range-checks one RCA config instruction (funct3 001-101), then issues a single config-bank write.
// Latency: accept at T, cfg_we at T+2, done_valid at T+3, ready again at T+4; each busy cycle of the target RCA adds one.
// Backpressure: issue_ready is low from accept until completion. RCA_CFG_ILLEGAL_TRAP_EN adds the done_illegal output.
module rca_cfg_decoder #(
    parameter int NUM_RCAS           = 4,
    parameter int NUM_READ_PORTS     = 5,
    parameter int NUM_WRITE_PORTS    = 5,
    parameter int NUM_GRID_MUXES     = 30,
    parameter int GRID_MUX_INPUTS    = 8,
    parameter int NUM_IO_UNITS       = 6,
    parameter int IO_UNIT_MUX_INPUTS = 12,
    parameter int ID_W               = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [2:0]          issue_funct3,
    input  logic [6:0]          issue_funct7,
    input  logic [31:0]         issue_rs1,
    input  logic [31:0]         issue_rs2,
    input  logic [ID_W-1:0]     issue_id,
    input  logic                flush,
    input  logic [NUM_RCAS-1:0] rca_busy,
    output logic                cfg_we,
    output logic [2:0]          cfg_type,
    output logic [1:0]          cfg_rca,
    output logic [4:0]          cfg_idx,
    output logic [1:0]          cfg_flags,
    output logic [5:0]          cfg_val,
    output logic                done_valid,
    output logic [ID_W-1:0]     done_id
`ifdef RCA_CFG_ILLEGAL_TRAP_EN
    ,
    output logic                done_illegal
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [31:0]     r_rs1;
    logic [31:0]     r_rs2;
    logic [ID_W-1:0] r_id;

    logic       w_fields_ok;
    logic       w_rca_ok;
    logic       w_legal;
    logic       w_busy;
    logic [4:0] w_idx;
    logic [1:0] w_flags;
    logic [5:0] w_val;

    assign w_rca_ok = ({25'd0, r_funct7} < 32'(NUM_RCAS));
    assign w_legal  = w_fields_ok & w_rca_ok;
    // Index is only meaningful when w_rca_ok; illegal targets never look at busy.
    assign w_busy   = rca_busy[r_funct7[1:0]];

    // Full 32-bit operands are range-checked so stray upper bits make the instruction illegal.
    always_comb begin
        w_fields_ok = 1'b0;
        w_idx       = 5'd0;
        w_flags     = 2'd0;
        w_val       = 6'd0;
        case (r_funct3)
            3'b001: begin
                w_idx       = {2'b00, r_rs1[2:0]};
                w_flags     = r_rs1[4:3];
                w_val       = {1'b0, r_rs2[4:0]};
                w_fields_ok = ~|r_rs1[31:5] && ~|r_rs2[31:5] &&
                              (r_rs1[3] ? (32'(r_rs1[2:0]) < 32'(NUM_WRITE_PORTS))
                                        : (32'(r_rs1[2:0]) < 32'(NUM_READ_PORTS)));
            end
            3'b010: begin
                w_idx       = r_rs1[4:0];
                w_val       = r_rs2[5:0];
                w_fields_ok = (r_rs1 < 32'(NUM_GRID_MUXES)) && (r_rs2 < 32'(GRID_MUX_INPUTS));
            end
            3'b011: begin
                w_idx       = r_rs1[4:0];
                w_val       = r_rs2[5:0];
                w_fields_ok = (r_rs1 < 32'(NUM_IO_UNITS)) && (r_rs2 < 32'(IO_UNIT_MUX_INPUTS));
            end
            3'b100: begin
                // rs2 == NUM_IO_UNITS encodes an unused port, hence <=.
                w_idx       = {2'b00, r_rs1[2:0]};
                w_flags     = {r_rs1[3], 1'b0};
                w_val       = r_rs2[5:0];
                w_fields_ok = ~|r_rs1[31:4] && (32'(r_rs1[2:0]) < 32'(NUM_WRITE_PORTS)) &&
                              (r_rs2 <= 32'(NUM_IO_UNITS));
            end
            3'b101: begin
                w_val       = 6'(r_rs1[NUM_IO_UNITS-1:0]);
                w_fields_ok = ((r_rs1 >> NUM_IO_UNITS) == 32'd0);
            end
            default: w_fields_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'd0;
            r_funct7    <= 7'd0;
            r_rs1       <= 32'd0;
            r_rs2       <= 32'd0;
            r_id        <= '0;
            issue_ready <= 1'b1;
            cfg_we      <= 1'b0;
            cfg_type    <= 3'd0;
            cfg_rca     <= 2'd0;
            cfg_idx     <= 5'd0;
            cfg_flags   <= 2'd0;
            cfg_val     <= 6'd0;
            done_valid  <= 1'b0;
            done_id     <= '0;
`ifdef RCA_CFG_ILLEGAL_TRAP_EN
            done_illegal <= 1'b0;
`endif
        end else begin
            cfg_we     <= 1'b0;
            done_valid <= 1'b0;
`ifdef RCA_CFG_ILLEGAL_TRAP_EN
            done_illegal <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (issue_valid) begin
                        r_funct3    <= issue_funct3;
                        r_funct7    <= issue_funct7;
                        r_rs1       <= issue_rs1;
                        r_rs2       <= issue_rs2;
                        r_id        <= issue_id;
                        issue_ready <= 1'b0;
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (flush) begin
                        issue_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (!w_legal) begin
                        done_valid <= 1'b1;
                        done_id    <= r_id;
`ifdef RCA_CFG_ILLEGAL_TRAP_EN
                        done_illegal <= 1'b1;
`endif
                        r_state    <= S_DONE;
                    end else if (!w_busy) begin
                        cfg_we    <= 1'b1;
                        cfg_type  <= r_funct3;
                        cfg_rca   <= r_funct7[1:0];
                        cfg_idx   <= w_idx;
                        cfg_flags <= w_flags;
                        cfg_val   <= w_val;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    done_valid <= 1'b1;
                    done_id    <= r_id;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    issue_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
